// File: rtl/eth_pkg.sv
// Shared Ethernet receive/transmit definitions: FSM states, CRC-32 constants,
// MII preamble/SFD nibbles and err_code bit positions.
package eth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_DROP
   } rx_state_e;

   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

   localparam logic [3:0] NIB_PREAMBLE = 4'h5;
   localparam logic [3:0] NIB_SFD      = 4'hD;

   localparam int ERR_CRC = 0;
   localparam int ERR_LEN = 1;
   localparam int ERR_PHY = 2;

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32 (LSB of the byte enters first).
// Purely combinational so both receive and transmit paths can wrap it in their own register.
module crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   localparam logic [31:0] POLY_REFL = bitrev32(CRC32_POLY);

   logic [31:0] crc_work;

   always_comb begin
      crc_work = crc_i;
      for (int i = 0; i < 8; i++) begin
         if (crc_work[0] ^ data_i[i]) crc_work = (crc_work >> 1) ^ POLY_REFL;
         else                         crc_work = crc_work >> 1;
      end
      crc_o = crc_work;
   end

endmodule

// File: rtl/mii_frame_receiver.sv
// MII nibble-to-byte frame receiver: preamble/SFD detection, byte assembly,
// FCS check, length policing and a per-frame status strobe.
module mii_frame_receiver
   import eth_pkg::*;
#(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1522
) (
   input  logic        eth_rx_clk,
   input  logic        eth_rx_rstn,
   input  logic [3:0]  eth_rx_d,
   input  logic        eth_rx_dv,
   input  logic        eth_rx_err,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   output logic        frame_start,
   output logic        frame_end,
   output logic        frame_good,
   output logic [2:0]  err_code,
   output logic [10:0] frame_len
);

   localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
   localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);

   logic        rst_meta_q, rst_sync_q;
   rx_state_e   state_q;
   logic        armed_q, in_frame_q, odd_q;
   logic [3:0]  low_nib_q;
   logic [10:0] cnt_q;
   logic [2:0]  err_q;
   logic [31:0] crc_q;
   logic [7:0]  byte_data_q;
   logic        byte_valid_q, frame_start_q, frame_end_q, frame_good_q;
   logic [2:0]  err_code_q;
   logic [10:0] frame_len_q;

   logic [31:0] crc_d;
   logic [10:0] cnt_d;
   logic        len_bad, crc_ok;
   logic [2:0]  end_err;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge eth_rx_clk or negedge eth_rx_rstn) begin
      if (!eth_rx_rstn) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   crc32_d8 u_crc (
      .crc_i  (crc_q),
      .data_i ({eth_rx_d, low_nib_q}),
      .crc_o  (crc_d)
   );

   assign cnt_d   = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
   assign len_bad = (cnt_q < MIN_LEN_C) || (cnt_q > MAX_LEN_C);
   // The register shifts right, so compare its bit-reversed image to the residue.
   assign crc_ok  = (bitrev32(crc_q) == CRC32_RESIDUE);

   always_comb begin
      end_err = err_q;
      if (len_bad) end_err[ERR_LEN] = 1'b1;
      if (odd_q)   end_err[ERR_PHY] = 1'b1;
      if (state_q == ST_DATA && !crc_ok) end_err[ERR_CRC] = 1'b1;
   end

   always_ff @(posedge eth_rx_clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         state_q       <= ST_IDLE;
         armed_q       <= 1'b0;
         in_frame_q    <= 1'b0;
         odd_q         <= 1'b0;
         low_nib_q     <= 4'h0;
         cnt_q         <= 11'd0;
         err_q         <= 3'b000;
         crc_q         <= CRC32_INIT;
         byte_data_q   <= 8'h00;
         byte_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         frame_good_q  <= 1'b0;
         err_code_q    <= 3'b000;
         frame_len_q   <= 11'd0;
      end else begin
         byte_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         // After a reset the tail of an interrupted frame must drain before we listen again.
         armed_q       <= armed_q | ~eth_rx_dv;
         case (state_q)
            ST_IDLE: begin
               if (eth_rx_dv && armed_q && eth_rx_d == NIB_PREAMBLE) state_q <= ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
               if (!eth_rx_dv) begin
                  state_q <= ST_IDLE;
               end else if (eth_rx_d == NIB_SFD) begin
                  state_q    <= ST_DATA;
                  in_frame_q <= 1'b1;
                  odd_q      <= 1'b0;
                  cnt_q      <= 11'd0;
                  err_q      <= 3'b000;
                  crc_q      <= CRC32_INIT;
               end else if (eth_rx_d != NIB_PREAMBLE) begin
                  state_q <= ST_DROP;
               end
            end
            ST_DATA: begin
               if (!eth_rx_dv) begin
                  frame_end_q  <= 1'b1;
                  frame_len_q  <= cnt_q;
                  err_code_q   <= end_err;
                  frame_good_q <= (end_err == 3'b000);
                  in_frame_q   <= 1'b0;
                  state_q      <= ST_IDLE;
               end else if (eth_rx_err) begin
                  err_q[ERR_PHY] <= 1'b1;
                  state_q        <= ST_DROP;
               end else if (!odd_q) begin
                  low_nib_q <= eth_rx_d;
                  odd_q     <= 1'b1;
               end else begin
                  odd_q <= 1'b0;
                  cnt_q <= cnt_d;
                  if (cnt_d > MAX_LEN_C) begin
                     err_q[ERR_LEN] <= 1'b1;
                     state_q        <= ST_DROP;
                  end else begin
                     byte_data_q   <= {eth_rx_d, low_nib_q};
                     byte_valid_q  <= 1'b1;
                     frame_start_q <= (cnt_q == 11'd0);
                     crc_q         <= crc_d;
                  end
               end
            end
            ST_DROP: begin
               if (!eth_rx_dv) begin
                  if (in_frame_q) begin
                     frame_end_q  <= 1'b1;
                     frame_len_q  <= cnt_q;
                     err_code_q   <= end_err;
                     frame_good_q <= (end_err == 3'b000);
                  end
                  in_frame_q <= 1'b0;
                  state_q    <= ST_IDLE;
               end else if (in_frame_q) begin
                  // Keep counting so the reported length reflects the whole frame.
                  odd_q <= ~odd_q;
                  if (odd_q) cnt_q <= cnt_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign byte_data   = byte_data_q;
   assign byte_valid  = byte_valid_q;
   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;
   assign frame_good  = frame_good_q;
   assign err_code    = err_code_q;
   assign frame_len   = frame_len_q;

endmodule

// File: tb/tb_mii_frame_receiver.sv
// Scoreboard bench for mii_frame_receiver: frames are built with their own FCS,
// expected bytes and frame status are queued at drive time and matched on output.
module tb_mii_frame_receiver;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  rx_d;
   logic        rx_dv;
   logic        rx_err;
   logic [7:0]  byte_data;
   logic        byte_valid, frame_start, frame_end, frame_good;
   logic [2:0]  err_code;
   logic [10:0] frame_len;

   typedef struct packed {
      logic [10:0] len;
      logic [2:0]  err;
      logic [2:0]  mask;
      logic        chk_len;
   } exp_frame_t;

   logic [8:0]  byte_q[$];
   exp_frame_t  frame_q[$];
   logic [7:0]  frame_buf[$];

   int n_checks = 0;
   int n_errors = 0;

   mii_frame_receiver dut (
      .eth_rx_clk  (clk),
      .eth_rx_rstn (rstn),
      .eth_rx_d    (rx_d),
      .eth_rx_dv   (rx_dv),
      .eth_rx_err  (rx_err),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .frame_good  (frame_good),
      .err_code    (err_code),
      .frame_len   (frame_len)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in;
      for (int k = 0; k < 8; k++) c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   task automatic build_frame(input int n_payload);
      logic [31:0] crc;
      frame_buf.delete();
      for (int i = 0; i < n_payload; i++) frame_buf.push_back(8'(i));
      crc = 32'hFFFFFFFF;
      foreach (frame_buf[i]) crc = crc_step(crc, frame_buf[i]);
      crc = ~crc;
      for (int k = 0; k < 4; k++) frame_buf.push_back(crc[8*k +: 8]);
   endtask

   task automatic send_nib(input logic [3:0] d, input logic er);
      @(negedge clk);
      rx_dv  = 1'b1;
      rx_d   = d;
      rx_err = er;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_dv  = 1'b0;
         rx_d   = 4'h0;
         rx_err = 1'b0;
      end
   endtask

   task automatic send_preamble();
      for (int i = 0; i < 15; i++) send_nib(4'h5, 1'b0);
      send_nib(4'hD, 1'b0);
   endtask

   task automatic push_exp(input int len, input logic [2:0] err, input logic [2:0] mask, input logic chk_len);
      exp_frame_t f;
      f.len = 11'(len); f.err = err; f.mask = mask; f.chk_len = chk_len;
      frame_q.push_back(f);
   endtask

   // Bytes with index < n_emit are expected on byte_data; err_byte gets eth_rx_err on its low nibble.
   task automatic send_frame(input int n_emit, input int err_byte, input logic extra_nib);
      send_preamble();
      foreach (frame_buf[i]) begin
         if (i < n_emit) byte_q.push_back({(i == 0), frame_buf[i]});
         send_nib(frame_buf[i][3:0], (i == err_byte));
         send_nib(frame_buf[i][7:4], 1'b0);
      end
      if (extra_nib) send_nib(4'hA, 1'b0);
      gap(12);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && (frame_q.size() != 0 || byte_q.size() != 0); i++) @(negedge clk);
      check_eq({tag, "_frames_left"}, 32'(frame_q.size()), 32'd0);
      check_eq({tag, "_bytes_left"}, 32'(byte_q.size()), 32'd0);
      frame_q.delete();
      byte_q.delete();
   endtask

   logic [8:0] mon_b;
   exp_frame_t mon_f;

   always @(negedge clk) begin
      if (byte_valid) begin
         if (byte_q.size() == 0) begin
            check_eq("unexpected_byte_valid", 32'(byte_data), 32'hFFFF_FFFF);
         end else begin
            mon_b = byte_q.pop_front();
            check_eq("byte_data", 32'(byte_data), 32'(mon_b[7:0]));
            check_eq("frame_start", 32'(frame_start), 32'(mon_b[8]));
         end
      end else if (frame_start) begin
         check_eq("frame_start_without_byte", 32'(frame_start), 32'd0);
      end
      if (frame_end) begin
         if (frame_q.size() == 0) begin
            check_eq("unexpected_frame_end", 32'(frame_end), 32'd0);
         end else begin
            mon_f = frame_q.pop_front();
            check_eq("err_code", 32'(err_code & mon_f.mask), 32'(mon_f.err & mon_f.mask));
            check_eq("frame_good", 32'(frame_good), 32'(mon_f.err == 3'b000));
            if (mon_f.chk_len) check_eq("frame_len", 32'(frame_len), 32'(mon_f.len));
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; rx_dv = 1'b0; rx_d = 4'h0; rx_err = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_byte_data", 32'(byte_data), 32'd0);
      check_eq("rst_byte_valid", 32'(byte_valid), 32'd0);
      check_eq("rst_frame_start", 32'(frame_start), 32'd0);
      check_eq("rst_frame_end", 32'(frame_end), 32'd0);
      check_eq("rst_frame_good", 32'(frame_good), 32'd0);
      check_eq("rst_err_code", 32'(err_code), 32'd0);
      check_eq("rst_frame_len", 32'(frame_len), 32'd0);
      rstn = 1'b1;
      gap(6);

      build_frame(60); push_exp(64, 3'b000, 3'b111, 1'b1);
      send_frame(64, -1, 1'b0); drain("good64");

      build_frame(60); frame_buf[10] = 8'hFF; push_exp(64, 3'b001, 3'b111, 1'b1);
      send_frame(64, -1, 1'b0); drain("crc_err");

      build_frame(56); push_exp(60, 3'b010, 3'b111, 1'b1);
      send_frame(60, -1, 1'b0); drain("short60");

      build_frame(60); push_exp(0, 3'b100, 3'b100, 1'b0);
      send_frame(20, 20, 1'b0); drain("phy_err");

      build_frame(60); push_exp(64, 3'b100, 3'b111, 1'b1);
      send_frame(64, -1, 1'b1); drain("odd_nibble");

      send_nib(4'h5, 1'b0); send_nib(4'h5, 1'b0); send_nib(4'h3, 1'b0);
      for (int i = 0; i < 20; i++) begin
         send_nib(4'(i), 1'b0); send_nib(4'hD, 1'b0);
      end
      gap(12); drain("bad_preamble");
      build_frame(60); push_exp(64, 3'b000, 3'b111, 1'b1);
      send_frame(64, -1, 1'b0); drain("after_bad_pre");

      build_frame(1518); push_exp(1522, 3'b000, 3'b111, 1'b1);
      send_frame(1522, -1, 1'b0); drain("max1522");

      build_frame(1519); push_exp(1523, 3'b010, 3'b111, 1'b1);
      send_frame(1522, -1, 1'b0); drain("over1523");

      build_frame(60);
      send_preamble();
      for (int i = 0; i < 30; i++) begin
         byte_q.push_back({(i == 0), frame_buf[i]});
         send_nib(frame_buf[i][3:0], 1'b0);
         send_nib(frame_buf[i][7:4], 1'b0);
      end
      send_nib(frame_buf[30][3:0], 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      rx_d = frame_buf[30][7:4];
      for (int i = 31; i < 41; i++) begin
         send_nib(frame_buf[i][3:0], 1'b0);
         send_nib(frame_buf[i][7:4], 1'b0);
      end
      check_eq("mid_rst_byte_valid", 32'(byte_valid), 32'd0);
      rstn = 1'b1;
      for (int i = 41; i < 64; i++) begin
         send_nib(frame_buf[i][3:0], 1'b0);
         send_nib(frame_buf[i][7:4], 1'b0);
      end
      gap(12); drain("mid_reset");
      build_frame(60); push_exp(64, 3'b000, 3'b111, 1'b1);
      send_frame(64, -1, 1'b0); drain("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
